// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and single-cycle special cases.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state;
  logic [2:0]           op;
  logic                 sign_a;
  logic                 sign_b;
  logic [CNT_WIDTH-1:0] count;
  logic [2*W-1:0]       acc;
  logic [W-1:0]         opnd;

  logic           a_signed, b_signed, in_sign_a, in_sign_b;
  logic [W-1:0]   abs_a, abs_b;
  logic           special;
  logic [W-1:0]   special_res;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] calc_next, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_res;

  // Operand decode and the ops that bypass iteration (divide by zero, signed overflow)
  always_comb begin
    a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    in_sign_a   = a_signed && op_a[W-1];
    in_sign_b   = b_signed && op_b[W-1];
    abs_a       = in_sign_a ? -op_a : op_a;
    abs_b       = in_sign_b ? -op_b : op_b;
    special     = 1'b0;
    special_res = '0;
    if (funct3[2] && (op_b == '0)) begin
      special     = 1'b1;
      special_res = funct3[1] ? op_a : '1;
    end else if (((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                 (op_a == MIN_NEG) && (op_b == '1)) begin
      special     = 1'b1;
      special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op[2]) begin
      if (div_diff[W])
        calc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      else
        calc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      calc_next = {mul_sum, acc[W-1:1]};
    end
  end

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
    rem_fix  = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op)
      3'b000:                 fix_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  assign stall = (start && (state == IDLE)) || (state == CALC) || (state == FIX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op     <= funct3;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            count  <= '0;
            opnd   <= funct3[2] ? abs_b : abs_a;
            acc    <= {{W{1'b0}}, (funct3[2] ? abs_a : abs_b)};
            busy   <= 1'b1;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= calc_next;
          count <= count + CNT_WIDTH'(1);
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
